uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART byte transmitter between up to NUM_REQ requesters (e.g. button-triggered message sender, RX echo path, status reporter). Each requester presents a byte stream with a packet-end marker. The arbiter locks the grant for a whole packet so messages never interleave on the serial line. It sits between the requesters and the transmitter's byte-level valid/ready input, and holds one registered output byte.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one UART byte transmitter between NUM_REQ
//   requesters. A grant is held for a whole packet (until a byte flagged with
//   req_last is accepted) so messages never interleave on the serial line.
//   A grant is revoked if no byte is accepted for IDLE_TIMEOUT cycles.
//   One registered output byte sits between the requesters and the transmitter.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   req_valid      per-requester byte valid
//   req_data       packed request bytes, requester i on [8i+7:8i]
//   req_last       per-requester packet-end marker
//   req_ready      per-requester accept (only the owner, only while buffer free)
//   tx_valid       registered byte available for the transmitter
//   tx_data        registered byte
//   tx_ready       transmitter takes tx_data this cycle
//   grant          one-hot owner of the transmitter, zero when none
//   busy           high while a packet is locked or draining
//   timeout_pulse  one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 27_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKED,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] idle_cnt;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             buf_free;
  logic             accept;
  logic [7:0]       owner_byte;

  // Round-robin search starting at rr_ptr; the first valid index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // The output buffer can take a new byte when empty or being emptied now.
  assign buf_free   = !tx_valid || tx_ready;
  assign owner_byte = req_data[{owner, 3'b000} +: 8];
  assign accept     = (state == S_LOCKED) && req_valid[owner] && buf_free;
  assign req_ready  = (state == S_LOCKED && buf_free) ? (ONE << owner) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      owner         <= '0;
      rr_ptr        <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      timeout_pulse <= 1'b0;
      idle_cnt      <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state    <= S_LOCKED;
            owner    <= win_idx;
            grant    <= ONE << win_idx;
            busy     <= 1'b1;
            idle_cnt <= '0;
          end
        end

        S_LOCKED: begin
          if (accept) begin
            tx_data  <= owner_byte;
            tx_valid <= 1'b1;
            idle_cnt <= '0;
            if (req_last[owner]) begin
              state <= S_DRAIN;
            end
          end else begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
            end
            if (idle_cnt == CNT_LAST) begin
              // Revoke the grant; any byte still buffered drains first.
              state         <= S_DRAIN;
              timeout_pulse <= 1'b1;
            end else if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (buf_free) begin
            tx_valid <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
            // The requester that just finished gets lowest priority next.
            rr_ptr   <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
            state    <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
